phasenoisepon_seven_segment_multi: RTL and testbench

Parametrised multi-digit successor to the single-digit seven-segment seconds counter. A prescaler divides clk into count ticks, and a DIGITS-wide BCD counter counts up or down with wrap and clear. The value is time-multiplexed onto one shared seven-segment bus with a one-hot digit select. It sits at the top of the design, driving the segment/digit pins directly.

---
 rtl/phasenoisepon_seven_segment_multi.sv | 178 +++++++++++++++++
 tb/tb_phasenoisepon_seven_segment_multi.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/phasenoisepon_seven_segment_multi.sv
// Multi-digit BCD up/down counter with a prescaler, time-multiplexed
// onto one shared seven-segment bus with a one-hot digit select.
//
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   en        : prescaler run enable (low holds prescaler and count)
//   up        : count direction, 1 = up, 0 = down, used on tick cycles
//   clear     : synchronous clear of prescaler and count
//   seg       : segments a..g on seg[0]..seg[6], active-high
//   digit_sel : one-hot digit enable, bit 0 = least significant digit
//   value     : BCD count, digit i at [4i+3:4i]
//   tick      : one-cycle pulse per count tick, aligned with new value
//   wrap      : one-cycle pulse when the count wraps
module phasenoisepon_seven_segment_multi #(
    parameter int MAX_COUNT = 10_000_000,
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 1024,
    parameter bit LZB       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clear,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [4*DIGITS-1:0]   value,
    output logic                  tick,
    output logic                  wrap
);

    localparam int PW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(MAX_COUNT - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    function automatic logic [6:0] dec7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [PW-1:0]            presc;
    logic [DIGITS-1:0][3:0]   dig;
    logic                     itick;

    logic [DIGITS-1:0][3:0]   inc_d;
    logic [DIGITS-1:0][3:0]   dec_d;
    logic                     all9;
    logic                     all0;

    logic [SW-1:0]            sdiv;
    logic [IW-1:0]            scan_idx;

    logic [DIGITS-1:0]        blank;
    logic [6:0]               seg_nxt;
    logic [DIGITS-1:0]        sel_nxt;

    assign itick = en && (presc == PRE_LAST);
    assign value = dig;

    // Ripple BCD increment/decrement; the final carry/borrow out
    // means every digit rolled over, i.e. the count wrapped.
    always_comb begin
        logic cy;
        logic bw;
        inc_d = dig;
        dec_d = dig;
        cy    = 1'b1;
        bw    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (cy) begin
                if (dig[i] == 4'd9) begin
                    inc_d[i] = 4'd0;
                end else begin
                    inc_d[i] = dig[i] + 4'd1;
                    cy       = 1'b0;
                end
            end
            if (bw) begin
                if (dig[i] == 4'd0) begin
                    dec_d[i] = 4'd9;
                end else begin
                    dec_d[i] = dig[i] - 4'd1;
                    bw       = 1'b0;
                end
            end
        end
        all9 = cy;
        all0 = bw;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            dig   <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (clear) begin
            presc <= '0;
            dig   <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            tick <= itick;
            wrap <= 1'b0;
            if (en) begin
                presc <= itick ? '0 : presc + PW'(1);
            end
            if (itick) begin
                if (up) begin
                    dig  <= inc_d;
                    wrap <= all9;
                end else begin
                    dig  <= dec_d;
                    wrap <= all0;
                end
            end
        end
    end

    // Scan runs freely; en and clear only govern the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdiv     <= '0;
            scan_idx <= '0;
        end else if (sdiv == SCAN_LAST) begin
            sdiv     <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
        end else begin
            sdiv <= sdiv + SW'(1);
        end
    end

    // Walk from the top digit down: a digit is blank while it and
    // everything above it is zero. Digit 0 always shows.
    always_comb begin
        logic nz;
        nz    = 1'b0;
        blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz       = nz | (dig[i] != 4'd0);
            blank[i] = LZB && (i != 0) && !nz;
        end
    end

    always_comb begin
        seg_nxt = blank[scan_idx] ? 7'h00 : dec7(dig[scan_idx]);
        sel_nxt = DIGITS'(1) << scan_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg       <= 7'h3F;
            digit_sel <= DIGITS'(1);
        end else begin
            seg       <= seg_nxt;
            digit_sel <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_phasenoisepon_seven_segment_multi.sv
// Scoreboard bench: three configurations share stimulus, each with
// its own behavioural model producing expected outputs per cycle.
module tb_phasenoisepon_seven_segment_multi;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic up = 1'b1;
    logic clear = 1'b0;

    logic [6:0] sa, sb, sc;
    logic [1:0] dsa, dsb;
    logic [0:0] dsc;
    logic [7:0] va, vb;
    logic [3:0] vc;
    logic ta, tb, tc, wa, wb, wc;

    always #5 clk = ~clk;

    phasenoisepon_seven_segment_multi #(
        .MAX_COUNT(4), .DIGITS(2), .SCAN_DIV(2), .LZB(1'b1)
    ) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear),
        .seg(sa), .digit_sel(dsa), .value(va), .tick(ta), .wrap(wa)
    );

    phasenoisepon_seven_segment_multi #(
        .MAX_COUNT(4), .DIGITS(2), .SCAN_DIV(2), .LZB(1'b0)
    ) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear),
        .seg(sb), .digit_sel(dsb), .value(vb), .tick(tb), .wrap(wb)
    );

    phasenoisepon_seven_segment_multi #(
        .MAX_COUNT(1), .DIGITS(1), .SCAN_DIV(3), .LZB(1'b1)
    ) u_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear),
        .seg(sc), .digit_sel(dsc), .value(vc), .tick(tc), .wrap(wc)
    );

    typedef struct {
        int         presc;
        int         cnt;
        int         sdiv;
        int         sidx;
        bit         tick;
        bit         wrap;
        logic [6:0] seg;
        int         sel;
    } mdl_t;

    typedef struct {
        mdl_t a;
        mdl_t b;
        mdl_t c;
    } exp_t;

    exp_t q[$];
    mdl_t ma, mb, mc;
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] dec(input int d);
        logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return t[d];
    endfunction

    function automatic logic [31:0] bcd(input int v, input int nd);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic mdl_t mreset();
        mdl_t m;
        m.presc = 0; m.cnt = 0; m.sdiv = 0; m.sidx = 0;
        m.tick = 0; m.wrap = 0; m.seg = 7'h3F; m.sel = 1;
        return m;
    endfunction

    function automatic mdl_t step(input mdl_t m, input int mx,
                                  input int nd, input int sd,
                                  input bit lz, input bit e,
                                  input bit u, input bit c);
        mdl_t n = m;
        int top = pow10(nd) - 1;
        int p = pow10(m.sidx);
        bit it = e && (m.presc == mx - 1);
        n.tick = 0;
        n.wrap = 0;
        if (c) begin
            n.presc = 0;
            n.cnt = 0;
        end else begin
            if (e) n.presc = it ? 0 : m.presc + 1;
            if (it) begin
                n.tick = 1;
                if (u) begin
                    n.wrap = (m.cnt == top);
                    n.cnt = (m.cnt == top) ? 0 : m.cnt + 1;
                end else begin
                    n.wrap = (m.cnt == 0);
                    n.cnt = (m.cnt == 0) ? top : m.cnt - 1;
                end
            end
        end
        n.sdiv = (m.sdiv == sd - 1) ? 0 : m.sdiv + 1;
        if (m.sdiv == sd - 1) n.sidx = (m.sidx + 1) % nd;
        n.seg = (lz && m.sidx > 0 && m.cnt < p) ? 7'h00
                                                : dec((m.cnt / p) % 10);
        n.sel = 1 << m.sidx;
        return n;
    endfunction

    task automatic cmp(input string n, input mdl_t m, input int nd,
                       input logic [31:0] v, input logic t,
                       input logic w, input logic [6:0] s,
                       input logic [31:0] sel);
        chk({n, ".value"}, v, bcd(m.cnt, nd));
        chk({n, ".tick"}, 32'(t), 32'(m.tick));
        chk({n, ".wrap"}, 32'(w), 32'(m.wrap));
        chk({n, ".seg"}, 32'(s), 32'(m.seg));
        chk({n, ".sel"}, sel, m.sel);
    endtask

    task automatic cmp_all(input exp_t x);
        cmp("a", x.a, 2, 32'(va), ta, wa, sa, 32'(dsa));
        cmp("b", x.b, 2, 32'(vb), tb, wb, sb, 32'(dsb));
        cmp("c", x.c, 1, 32'(vc), tc, wc, sc, 32'(dsc));
    endtask

    task automatic cyc(input bit r, input bit e, input bit u,
                       input bit c);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; up = u; clear = c;
        if (r) begin
            ma = mreset(); mb = mreset(); mc = mreset();
        end else begin
            ma = step(ma, 4, 2, 2, 1'b1, e, u, c);
            mb = step(mb, 4, 2, 2, 1'b0, e, u, c);
            mc = step(mc, 1, 1, 3, 1'b1, e, u, c);
        end
        q.push_back('{ma, mb, mc});
        @(posedge clk);
        #1;
        x = q.pop_front();
        cmp_all(x);
    endtask

    initial begin
        ma = mreset(); mb = mreset(); mc = mreset();
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (13) cyc(1'b0, 1'b1, 1'b1, 1'b0);

        // asynchronous reset between edges, checked before any edge
        #2;
        rst = 1'b1;
        #1;
        ma = mreset(); mb = mreset(); mc = mreset();
        cmp_all('{ma, mb, mc});
        repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0);

        // up count through 09->10 and 99->00 wrap
        repeat (410) cyc(1'b0, 1'b1, 1'b1, 1'b0);

        // hold
        repeat (10) cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // clear on an internal tick cycle
        for (int k = 0; k < 8 && ma.presc != 3; k++)
            cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (12) cyc(1'b0, 1'b1, 1'b1, 1'b0);

        // down count through 00->99 wrap
        repeat (60) cyc(1'b0, 1'b1, 1'b0, 1'b0);

        // 10 -> 09 borrow
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (40) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (8) cyc(1'b0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
